// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch redirect controller: FSM states and redirect-source codes.
// No logic here, so it adds no latency and no backpressure.
package fetch_ctrl_pkg;

  localparam int ADDR_W_DEF = 30;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    PEND = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PEND = 2'd1,
    SRC_EX   = 2'd2,
    SRC_ID   = 2'd3
  } src_t;

endpackage

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
// Saturating up-counter: one step per cycle with inc high; it holds at all-ones and never wraps.
// Count is registered, so it is visible one edge after inc. No backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch sequencing: arbitrates redirects against load-use stalls and a slow imem.
// Outputs are zero-latency combinational; one redirect is parked while imem is busy.
module fetch_redirect_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_ready,
  input  logic              stall_req,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              id_redirect,
  input  logic [ADDR_W-1:0] id_target,
  output logic              pc_src,
  output logic [ADDR_W-1:0] target_pc_addr,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [CNT_W-1:0]  redirect_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pend_target, pend_target_nxt;
  src_t              src;
  logic [ADDR_W-1:0] cand_target;
  logic              redirect_applied;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      pend_target <= '0;
    end else begin
      state       <= state_nxt;
      pend_target <= pend_target_nxt;
    end
  end

  // A parked redirect outranks everything; newer redirects behind it are wrong-path.
  always_comb begin
    src         = SRC_NONE;
    cand_target = '0;
    if (state == PEND) begin
      src         = SRC_PEND;
      cand_target = pend_target;
    end else if (ex_redirect) begin
      src         = SRC_EX;
      cand_target = ex_target;
    end else if (id_redirect && !stall_req) begin
      src         = SRC_ID;
      cand_target = id_target;
    end
  end

  always_comb begin
    state_nxt        = state;
    pend_target_nxt  = pend_target;
    pc_src           = 1'b0;
    target_pc_addr   = '0;
    pc_we            = 1'b0;
    ifid_we          = 1'b0;
    ifid_flush       = 1'b0;
    idex_flush       = 1'b0;
    redirect_applied = 1'b0;
    if (!rst) begin
      state_nxt       = RUN;
      pend_target_nxt = '0;
    end else if (src != SRC_NONE) begin
      ifid_we    = 1'b1;
      ifid_flush = 1'b1;
      if (imem_ready) begin
        pc_src           = 1'b1;
        target_pc_addr   = cand_target;
        pc_we            = 1'b1;
        idex_flush       = (src == SRC_EX);
        redirect_applied = 1'b1;
        state_nxt        = RUN;
      end else begin
        // Only a fresh EX source still has a live ID/EX to kill; a parked one already did.
        idex_flush      = (src == SRC_EX);
        pend_target_nxt = cand_target;
        state_nxt       = PEND;
      end
    end else if (stall_req) begin
      idex_flush = 1'b1;
      state_nxt  = imem_ready ? RUN : WAIT;
    end else if (!imem_ready) begin
      ifid_we    = 1'b1;
      ifid_flush = 1'b1;
      state_nxt  = WAIT;
    end else begin
      pc_we     = 1'b1;
      ifid_we   = 1'b1;
      state_nxt = RUN;
    end
  end

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect_applied),
    .cnt (redirect_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ifid_flush | idex_flush),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl; a second 4-bit-counter instance covers saturation.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_ready = 1'b0;
  logic        stall_req = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [29:0] ex_target = '0;
  logic        id_redirect = 1'b0;
  logic [29:0] id_target = '0;
  logic        pc_src, pc_we, ifid_we, ifid_flush, idex_flush;
  logic [29:0] target_pc_addr;
  logic [15:0] redirect_cnt, bubble_cnt;

  logic        rst_s = 1'b0;
  logic        stall_s = 1'b0;
  logic        pc_src_s, pc_we_s, ifid_we_s, ifid_flush_s, idex_flush_s;
  logic [29:0] target_s;
  logic [3:0]  redirect_cnt_s, bubble_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .stall_req(stall_req),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .id_redirect(id_redirect), .id_target(id_target),
    .pc_src(pc_src), .target_pc_addr(target_pc_addr), .pc_we(pc_we),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .redirect_cnt(redirect_cnt), .bubble_cnt(bubble_cnt)
  );

  fetch_redirect_ctrl #(.ADDR_W(30), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst_s), .imem_ready(1'b1), .stall_req(stall_s),
    .ex_redirect(1'b0), .ex_target(30'h0),
    .id_redirect(1'b0), .id_target(30'h0),
    .pc_src(pc_src_s), .target_pc_addr(target_s), .pc_we(pc_we_s),
    .ifid_we(ifid_we_s), .ifid_flush(ifid_flush_s), .idex_flush(idex_flush_s),
    .redirect_cnt(redirect_cnt_s), .bubble_cnt(bubble_cnt_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ex_redirect = 1'b1; ex_target = 30'h3; imem_ready = 1'b1;
    #3;
    checks++; if ({pc_src, pc_we, ifid_we, ifid_flush, idex_flush} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {pc_src, pc_we, ifid_we, ifid_flush, idex_flush});
    end
    checks++; if (target_pc_addr !== 30'h0) begin
      errors++; $display("FAIL reset_target got %h want 0", target_pc_addr);
    end
    checks++; if (redirect_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", redirect_cnt, bubble_cnt);
    end
    tick();
    ex_redirect = 1'b0; ex_target = '0;
    rst = 1'b1;
    #3;
    checks++; if ({pc_src, pc_we, ifid_we, ifid_flush, idex_flush} !== 5'b01100) begin
      errors++; $display("FAIL run_ctrl got %b want 01100", {pc_src, pc_we, ifid_we, ifid_flush, idex_flush});
    end
    tick();
  endtask

  task automatic test_ex_redirect();
    ex_redirect = 1'b1; ex_target = 30'h100;
    #3;
    checks++; if ({pc_src, pc_we, ifid_flush, idex_flush} !== 4'b1111 || target_pc_addr !== 30'h100) begin
      errors++; $display("FAIL ex_redir got %b/%h want 1111/100", {pc_src, pc_we, ifid_flush, idex_flush}, target_pc_addr);
    end
    checks++; if (redirect_cnt !== 16'd0) begin
      errors++; $display("FAIL ex_cnt_before got %0d want 0", redirect_cnt);
    end
    tick();
    ex_redirect = 1'b0;
    #3;
    checks++; if (redirect_cnt !== 16'd1 || bubble_cnt !== 16'd1) begin
      errors++; $display("FAIL ex_cnt_after got %0d/%0d want 1/1", redirect_cnt, bubble_cnt);
    end
  endtask

  task automatic test_stall_id();
    stall_req = 1'b1; id_redirect = 1'b1; id_target = 30'h40;
    #3;
    checks++; if ({pc_src, pc_we, ifid_we, ifid_flush, idex_flush} !== 5'b00001 || target_pc_addr !== 30'h0) begin
      errors++; $display("FAIL stall_id got %b/%h want 00001/0", {pc_src, pc_we, ifid_we, ifid_flush, idex_flush}, target_pc_addr);
    end
    tick();
    stall_req = 1'b0;
    #3;
    checks++; if ({pc_src, pc_we, ifid_flush, idex_flush} !== 4'b1110 || target_pc_addr !== 30'h40) begin
      errors++; $display("FAIL id_after_stall got %b/%h want 1110/40", {pc_src, pc_we, ifid_flush, idex_flush}, target_pc_addr);
    end
    tick();
    id_redirect = 1'b0;
    #3;
    checks++; if (redirect_cnt !== 16'd2 || bubble_cnt !== 16'd3) begin
      errors++; $display("FAIL id_cnt got %0d/%0d want 2/3", redirect_cnt, bubble_cnt);
    end
  endtask

  task automatic test_stall_ex();
    stall_req = 1'b1; ex_redirect = 1'b1; ex_target = 30'h80;
    id_redirect = 1'b1; id_target = 30'h40;
    #3;
    checks++; if ({pc_src, pc_we, ifid_flush, idex_flush} !== 4'b1111 || target_pc_addr !== 30'h80) begin
      errors++; $display("FAIL stall_ex got %b/%h want 1111/80", {pc_src, pc_we, ifid_flush, idex_flush}, target_pc_addr);
    end
    tick();
    stall_req = 1'b0; ex_redirect = 1'b0; id_redirect = 1'b0;
    #3;
    checks++; if (redirect_cnt !== 16'd3 || bubble_cnt !== 16'd4) begin
      errors++; $display("FAIL stall_ex_cnt got %0d/%0d want 3/4", redirect_cnt, bubble_cnt);
    end
  endtask

  task automatic test_pend();
    imem_ready = 1'b0; ex_redirect = 1'b1; ex_target = 30'h200;
    #3;
    checks++; if ({pc_src, pc_we, ifid_flush, idex_flush} !== 4'b0011 || target_pc_addr !== 30'h0) begin
      errors++; $display("FAIL pend_capture got %b/%h want 0011/0", {pc_src, pc_we, ifid_flush, idex_flush}, target_pc_addr);
    end
    tick();
    ex_redirect = 1'b0; id_redirect = 1'b1; id_target = 30'h10;
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++; if (pc_src !== 1'b0 || pc_we !== 1'b0 || target_pc_addr !== 30'h0) begin
        errors++; $display("FAIL pend_busy%0d got %b%b/%h want 00/0", i, pc_src, pc_we, target_pc_addr);
      end
      tick();
    end
    imem_ready = 1'b1;
    #3;
    checks++; if ({pc_src, pc_we, idex_flush} !== 3'b110 || target_pc_addr !== 30'h200) begin
      errors++; $display("FAIL pend_apply got %b/%h want 110/200", {pc_src, pc_we, idex_flush}, target_pc_addr);
    end
    tick();
    id_redirect = 1'b0;
    #3;
    checks++; if ({pc_src, pc_we, ifid_flush, idex_flush} !== 4'b0100 || redirect_cnt !== 16'd4) begin
      errors++; $display("FAIL pend_to_run got %b/%0d want 0100/4", {pc_src, pc_we, ifid_flush, idex_flush}, redirect_cnt);
    end
  endtask

  task automatic test_async_reset();
    imem_ready = 1'b0; ex_redirect = 1'b1; ex_target = 30'h55;
    tick();
    ex_redirect = 1'b0;
    #2;
    rst = 1'b0;
    imem_ready = 1'b1;
    #1;
    checks++; if ({pc_src, pc_we, ifid_we, ifid_flush, idex_flush} !== 5'b0 || target_pc_addr !== 30'h0) begin
      errors++; $display("FAIL arst_ctrl got %b/%h want 00000/0", {pc_src, pc_we, ifid_we, ifid_flush, idex_flush}, target_pc_addr);
    end
    checks++; if (redirect_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL arst_cnt got %0d/%0d want 0/0", redirect_cnt, bubble_cnt);
    end
    tick();
    rst = 1'b1;
    #3;
    checks++; if ({pc_src, pc_we} !== 2'b01 || target_pc_addr !== 30'h0) begin
      errors++; $display("FAIL arst_release got %b/%h want 01/0", {pc_src, pc_we}, target_pc_addr);
    end
    tick();
    ex_redirect = 1'b1; ex_target = 30'h7;
    tick();
    ex_redirect = 1'b0;
    #3;
    checks++; if (redirect_cnt !== 16'd1) begin
      errors++; $display("FAIL arst_cnt_restart got %0d want 1", redirect_cnt);
    end
  endtask

  task automatic test_saturation();
    stall_s = 1'b1;
    tick();
    rst_s = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      #3;
      checks++; if (bubble_cnt_s !== ((k < 15) ? 4'(k) : 4'hF)) begin
        errors++; $display("FAIL sat_bubble cycle %0d got %h want %h", k, bubble_cnt_s, (k < 15) ? 4'(k) : 4'hF);
      end
    end
    checks++; if (redirect_cnt_s !== 4'h0 || idex_flush_s !== 1'b1) begin
      errors++; $display("FAIL sat_other got %h/%b want 0/1", redirect_cnt_s, idex_flush_s);
    end
    stall_s = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ex_redirect();
    test_stall_id();
    test_stall_ex();
    test_pend();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
